// File: rtl/alif_param_pkg.sv
// Shared state type and sizing helpers for the ALIF serial parameter-load path.
// Frame length accounts for the optional per-word parity bit (ALIF_PARAM_PARITY_EN).
package alif_param_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Word geometry shared with the neuron's receiver.
  localparam int DEFAULT_PARAM_W    = 8;
  localparam int DEFAULT_NUM_PARAMS = 4;

`ifdef ALIF_PARAM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_bits(input int param_w, input int num_params);
    return num_params * (param_w + PARITY_BITS);
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alif_bit_timer.sv
// BIT_CYCLES prescaler: strobes o_bit_adv on the last clock of each serial bit.
// Holds at zero while i_clear is high so every frame starts on a fresh bit period.
module alif_bit_timer
  import alif_param_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_adv
);

  localparam int               CNT_W = cnt_width(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == LAST);
  assign o_bit_adv = i_en & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alif_param_serializer.sv
// Host-side serializer for the ALIF neuron parameter load: shifts a latched block out
// MSB-first on load_mode/serial_data, then waits for params_ready. Parity: ALIF_PARAM_PARITY_EN.
module alif_param_serializer
  import alif_param_pkg::*;
#(
  parameter int PARAM_W       = DEFAULT_PARAM_W,
  parameter int NUM_PARAMS    = DEFAULT_NUM_PARAMS,
  parameter int BIT_CYCLES    = 1,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [NUM_PARAMS*PARAM_W-1:0] i_param_bus,
  input  logic                          i_params_ready,
  output logic                          o_load_mode,
  output logic                          o_serial_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout_err
);

  localparam int WORD_SLOT = PARAM_W + PARITY_BITS;
  localparam int FRAME_N   = frame_bits(PARAM_W, NUM_PARAMS);
  localparam int BIT_CNT_W = cnt_width(FRAME_N - 1);
  localparam int TO_CNT_W  = cnt_width(READY_TIMEOUT);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_N - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(READY_TIMEOUT - 1);

  state_e                r_state;
  state_e                w_next_state;
  logic [FRAME_N-1:0]    r_shift;
  logic [FRAME_N-1:0]    w_frame;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [TO_CNT_W-1:0]   r_to_cnt;
  logic                  r_seen_low;
  logic                  r_timeout_err;
  logic                  w_bit_adv;
  logic                  w_accept;
  logic                  w_last_bit;
  logic                  w_ack;
  logic                  w_timeout;

  // Word 0 sits at the MSB end so a plain left shift emits the frame in order.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_PARAMS; k++) begin
      w_frame[FRAME_N-1-k*WORD_SLOT -: PARAM_W] = i_param_bus[k*PARAM_W +: PARAM_W];
`ifdef ALIF_PARAM_PARITY_EN
      w_frame[FRAME_N-1-k*WORD_SLOT-PARAM_W] = ^i_param_bus[k*PARAM_W +: PARAM_W];
`endif
    end
  end

  alif_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != SHIFT),
    .i_en     (r_state == SHIFT),
    .o_bit_adv(w_bit_adv)
  );

  // A ready level that never dropped during this frame is stale and not an acknowledge.
  assign w_accept      = (r_state == IDLE) & i_start;
  assign w_last_bit    = w_bit_adv & (r_bit_cnt == LAST_BIT);
  assign w_ack         = i_params_ready & r_seen_low;
  assign w_timeout     = ~w_ack & (r_to_cnt == TO_LAST);
  assign o_timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    o_load_mode   = 1'b0;
    o_serial_data = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = SHIFT;
      end
      SHIFT: begin
        o_load_mode   = 1'b1;
        o_serial_data = r_shift[FRAME_N-1];
        o_busy        = 1'b1;
        if (w_last_bit) w_next_state = WAIT_RDY;
      end
      WAIT_RDY: begin
        o_busy = 1'b1;
        if (w_ack || w_timeout) w_next_state = DONE;
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_seen_low    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_shift       <= w_frame;
      r_bit_cnt     <= '0;
      r_seen_low    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == SHIFT || r_state == WAIT_RDY) && !i_params_ready) begin
        r_seen_low <= 1'b1;
      end
      if (r_state == SHIFT) begin
        r_to_cnt <= '0;
        if (w_bit_adv && !w_last_bit) begin
          r_shift   <= {r_shift[FRAME_N-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      if (r_state == WAIT_RDY && !w_ack) begin
        if (w_timeout) begin
          r_timeout_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alif_param_serializer.sv
// Bench for alif_param_serializer: two instances (BIT_CYCLES 1 and 3, READY_TIMEOUT 10)
// driven from a vector table, hand sequences and random frames against a stream model.
module tb_alif_param_serializer;

  localparam int PW = 8;
  localparam int NP = 4;
  localparam int RT = 10;
`ifdef ALIF_PARAM_PARITY_EN
  localparam int PAR = 1;
  localparam logic [63:0] STREAM_MAIN = {28'd0, 8'h81, 1'b0, 8'h0F, 1'b0, 8'h3C, 1'b0, 8'hA5, 1'b0};
  localparam logic [63:0] STREAM_ALT  = {28'd0, 8'h81, 1'b0, 8'h0F, 1'b0, 8'h07, 1'b1, 8'h00, 1'b0};
`else
  localparam int PAR = 0;
  localparam logic [63:0] STREAM_MAIN = {32'd0, 8'h81, 8'h0F, 8'h3C, 8'hA5};
  localparam logic [63:0] STREAM_ALT  = {32'd0, 8'h81, 8'h0F, 8'h07, 8'h00};
`endif
  localparam int FB = NP * (PW + PAR);

  typedef struct {
    logic [31:0] bus;
    int          s;
    int          riseAt;
    bit          disturb;
    int          expLoad;
    logic [63:0] expStream;
    int          expDoneAt;
    bit          expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        params_ready = 1'b1;
  logic [31:0] param_bus = '0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  logic d1Load, d1Ser, d1Busy, d1Done, d1Err;
  logic d3Load, d3Ser, d3Busy, d3Done, d3Err;
  logic load, ser, busy, done, terr;

  always #5 clk = ~clk;

  alif_param_serializer #(
    .PARAM_W(PW), .NUM_PARAMS(NP), .BIT_CYCLES(1), .READY_TIMEOUT(RT)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start & (sel == 0)), .i_param_bus(param_bus),
    .i_params_ready(params_ready), .o_load_mode(d1Load), .o_serial_data(d1Ser),
    .o_busy(d1Busy), .o_done(d1Done), .o_timeout_err(d1Err)
  );

  alif_param_serializer #(
    .PARAM_W(PW), .NUM_PARAMS(NP), .BIT_CYCLES(3), .READY_TIMEOUT(RT)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start & (sel == 1)), .i_param_bus(param_bus),
    .i_params_ready(params_ready), .o_load_mode(d3Load), .o_serial_data(d3Ser),
    .o_busy(d3Busy), .o_done(d3Done), .o_timeout_err(d3Err)
  );

  assign load = (sel == 1) ? d3Load : d1Load;
  assign ser  = (sel == 1) ? d3Ser  : d1Ser;
  assign busy = (sel == 1) ? d3Busy : d1Busy;
  assign done = (sel == 1) ? d3Done : d1Done;
  assign terr = (sel == 1) ? d3Err  : d1Err;

  // Expected serial stream: words 0..NP-1, MSB first, optional XOR parity after each word.
  function automatic logic [63:0] modelStream(input logic [31:0] bus);
    logic [63:0] s;
    logic [7:0]  w;
    s = '0;
    for (int k = 0; k < NP; k++) begin
      w = bus[k*8 +: 8];
      for (int b = 7; b >= 0; b--) s = {s[62:0], w[b]};
      if (PAR == 1) s = {s[62:0], ^w};
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] bus, input int s);
    @(negedge clk);
    sel          = s;
    param_bus    = bus;
    params_ready = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runFrame(input vec_t v, input string tag);
    int   bc, n, badBits, idx, doneAt, dones, extraLoad;
    logic errAtDone, busyAtDone;
    bc = (v.s == 1) ? 3 : 1;
    applyStimulus(v.bus, v.s);
    checkOutput({tag, "_load_rise"}, int'(load), 1);
    checkOutput({tag, "_err_clear"}, int'(terr), 0);
    if (v.riseAt >= 0) params_ready = 1'b0;
    n = 0;
    badBits = 0;
    while (load === 1'b1 && n < v.expLoad + 8) begin
      idx = FB - 1 - n / bc;
      if (idx >= 0 && ser !== v.expStream[idx]) badBits++;
      if (v.disturb && n == 5 * bc) begin
        start     = 1'b1;
        param_bus = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, "_load_cycles"}, n, v.expLoad);
    checkOutput({tag, "_stream_bad_bits"}, badBits, 0);
    checkOutput({tag, "_ser_idle"}, int'(ser), 0);
    checkOutput({tag, "_busy_wait"}, int'(busy), 1);
    doneAt = -1;
    dones = 0;
    extraLoad = 0;
    errAtDone = 1'b0;
    busyAtDone = 1'b1;
    for (int w = 0; w < RT + 30; w++) begin
      if (done === 1'b1) begin
        dones++;
        if (doneAt < 0) begin
          doneAt     = w;
          errAtDone  = terr;
          busyAtDone = busy;
        end
      end
      if (load === 1'b1) extraLoad++;
      if (w == v.riseAt) params_ready = 1'b1;
      if (doneAt >= 0 && w >= doneAt + 4) break;
      @(negedge clk);
    end
    checkOutput({tag, "_done_at"}, doneAt, v.expDoneAt);
    checkOutput({tag, "_done_count"}, dones, 1);
    checkOutput({tag, "_timeout_err"}, int'(errAtDone), int'(v.expErr));
    checkOutput({tag, "_busy_at_done"}, int'(busyAtDone), 0);
    checkOutput({tag, "_extra_frame"}, extraLoad, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    vecs[0] = '{32'hA53C0F81, 0, 3,      1'b0, FB,     STREAM_MAIN, 4,  1'b0};
    vecs[1] = '{32'hA53C0F81, 1, 3,      1'b0, FB * 3, STREAM_MAIN, 4,  1'b0};
    vecs[2] = '{32'hA53C0F81, 0, -1,     1'b0, FB,     STREAM_MAIN, RT, 1'b1};
    vecs[3] = '{32'h00070F81, 0, 3,      1'b1, FB,     STREAM_ALT,  4,  1'b0};
    vecs[4] = '{32'h00070F81, 1, RT - 1, 1'b1, FB * 3, STREAM_ALT,  RT, 1'b0};
    vecs[5] = '{32'hA53C0F81, 1, 20,     1'b0, FB * 3, STREAM_MAIN, RT, 1'b1};

    #1;
    checkOutput("reset_outputs",
                int'({d1Load, d1Ser, d1Busy, d1Done, d1Err, d3Load, d3Ser, d3Busy, d3Done, d3Err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runFrame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a frame must kill the frame without waiting for a clock.
    applyStimulus(32'hA53C0F81, 0);
    repeat (17) @(negedge clk);
    checkOutput("pre_reset_load", int'(load), 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_async", int'({load, ser, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", int'({busy, done, terr}), 0);
    runFrame(vecs[0], "after_reset");

    for (int i = 0; i < 8; i++) begin
      rv.bus       = $urandom;
      rv.s         = int'($urandom_range(0, 1));
      rv.riseAt    = int'($urandom_range(0, RT + 3));
      rv.disturb   = 1'($urandom_range(0, 1));
      rv.expLoad   = FB * ((rv.s == 1) ? 3 : 1);
      rv.expStream = modelStream(rv.bus);
      rv.expDoneAt = (rv.riseAt < RT) ? rv.riseAt + 1 : RT;
      rv.expErr    = (rv.riseAt >= RT);
      runFrame(rv, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
